// File: rtl/guess_entry.sv
// Guess entry front end: synchronises and debounces the key pad and enter button,
// builds a two-digit decimal value and commits it on enter.
module guess_entry #(
    parameter int DB_CNT = 16,
    parameter int DB_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] DIP,
    input  logic       enter,
    input  logic       clear,
    output logic [7:0] datain,
    output logic       data_valid,
    output logic [7:0] entry,
    output logic [1:0] ndigits,
    output logic       overflow
);

    typedef enum logic [1:0] {IDLE, ONE, TWO} state_t;

    // {valid, digit}; anything other than exactly one key is "no key"
    function automatic logic [4:0] f_decode(input logic [9:0] k);
        logic [4:0] d;
        case (k)
            10'b0000000001: d = {1'b1, 4'd0};
            10'b0000000010: d = {1'b1, 4'd9};
            10'b0000000100: d = {1'b1, 4'd8};
            10'b0000001000: d = {1'b1, 4'd7};
            10'b0000010000: d = {1'b1, 4'd6};
            10'b0000100000: d = {1'b1, 4'd5};
            10'b0001000000: d = {1'b1, 4'd4};
            10'b0010000000: d = {1'b1, 4'd3};
            10'b0100000000: d = {1'b1, 4'd2};
            10'b1000000000: d = {1'b1, 4'd1};
            default:        d = 5'd0;
        endcase
        return d;
    endfunction

    logic [9:0]      r_dip_s1, r_dip_s2, r_dip_cand, r_dip_db, r_dip_prev;
    logic            r_ent_s1, r_ent_s2, r_ent_cand, r_ent_db, r_ent_prev;
    logic            r_clr_s1, r_clr_s2;
    logic [DB_W-1:0] r_dip_cnt, r_ent_cnt;

    state_t     r_state, w_state_nxt;
    logic [6:0] r_entry, w_entry_nxt;
    logic [1:0] r_ndigits, w_ndigits_nxt;
    logic       r_overflow, w_overflow_nxt;
    logic [7:0] r_datain, w_datain_nxt;
    logic       r_valid, w_valid_nxt;

    logic [4:0] w_dec;
    logic       w_key_evt, w_ent_evt;
    logic [7:0] w_acc_x10;

    // Synchroniser and debounce stage. The candidate load clock counts as the
    // first stable clock, so the debounced value loads DB_CNT synced clocks in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dip_s1   <= '0;
            r_dip_s2   <= '0;
            r_dip_cand <= '0;
            r_dip_db   <= '0;
            r_dip_prev <= '0;
            r_dip_cnt  <= '0;
            r_ent_s1   <= 1'b0;
            r_ent_s2   <= 1'b0;
            r_ent_cand <= 1'b0;
            r_ent_db   <= 1'b0;
            r_ent_prev <= 1'b0;
            r_ent_cnt  <= '0;
            r_clr_s1   <= 1'b0;
            r_clr_s2   <= 1'b0;
        end else begin
            r_dip_s1   <= DIP;
            r_dip_s2   <= r_dip_s1;
            r_ent_s1   <= enter;
            r_ent_s2   <= r_ent_s1;
            r_clr_s1   <= clear;
            r_clr_s2   <= r_clr_s1;
            r_dip_prev <= r_dip_db;
            r_ent_prev <= r_ent_db;

            if (r_dip_s2 != r_dip_cand) begin
                r_dip_cand <= r_dip_s2;
                r_dip_cnt  <= '0;
            end else if (r_dip_cnt == DB_W'(DB_CNT - 2)) begin
                r_dip_db <= r_dip_cand;
            end else begin
                r_dip_cnt <= r_dip_cnt + 1'b1;
            end

            if (r_ent_s2 != r_ent_cand) begin
                r_ent_cand <= r_ent_s2;
                r_ent_cnt  <= '0;
            end else if (r_ent_cnt == DB_W'(DB_CNT - 2)) begin
                r_ent_db <= r_ent_cand;
            end else begin
                r_ent_cnt <= r_ent_cnt + 1'b1;
            end
        end
    end

    // A key only counts when the pad was fully released before it
    assign w_dec     = f_decode(r_dip_db);
    assign w_key_evt = (r_dip_prev == 10'd0) && w_dec[4];
    assign w_ent_evt = r_ent_db && !r_ent_prev;
    assign w_acc_x10 = 8'(r_entry) * 8'd10 + 8'(w_dec[3:0]);

    always_comb begin
        w_state_nxt    = r_state;
        w_entry_nxt    = r_entry;
        w_ndigits_nxt  = r_ndigits;
        w_overflow_nxt = r_overflow;
        w_datain_nxt   = r_datain;
        w_valid_nxt    = 1'b0;
        if (r_clr_s2) begin
            w_state_nxt    = IDLE;
            w_entry_nxt    = '0;
            w_ndigits_nxt  = '0;
            w_overflow_nxt = 1'b0;
        end else if (w_ent_evt) begin
            w_datain_nxt   = {1'b0, r_entry};
            w_valid_nxt    = 1'b1;
            w_state_nxt    = IDLE;
            w_entry_nxt    = '0;
            w_ndigits_nxt  = '0;
            w_overflow_nxt = 1'b0;
        end else if (w_key_evt) begin
            case (r_state)
                IDLE: begin
                    if (w_dec[3:0] != 4'd0) begin
                        w_entry_nxt   = {3'b000, w_dec[3:0]};
                        w_ndigits_nxt = 2'd1;
                        w_state_nxt   = ONE;
                    end
                end
                ONE: begin
                    w_entry_nxt   = w_acc_x10[6:0];
                    w_ndigits_nxt = 2'd2;
                    w_state_nxt   = TWO;
                end
                TWO:     w_overflow_nxt = 1'b1;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Accumulator / commit stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_entry    <= '0;
            r_ndigits  <= '0;
            r_overflow <= 1'b0;
            r_datain   <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_entry    <= w_entry_nxt;
            r_ndigits  <= w_ndigits_nxt;
            r_overflow <= w_overflow_nxt;
            r_datain   <= w_datain_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign datain     = r_datain;
    assign data_valid = r_valid;
    assign entry      = {1'b0, r_entry};
    assign ndigits    = r_ndigits;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry with DB_CNT=4; inputs change and outputs are
// sampled on the falling edge.
module tb_guess_entry;

    logic       clk;
    logic       rst;
    logic [9:0] DIP;
    logic       enter;
    logic       clear;
    logic [7:0] datain;
    logic       data_valid;
    logic [7:0] entry;
    logic [1:0] ndigits;
    logic       overflow;

    int n_tests;
    int n_fail;
    int pulses;

    guess_entry #(.DB_CNT(4), .DB_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .DIP        (DIP),
        .enter      (enter),
        .clear      (clear),
        .datain     (datain),
        .data_valid (data_valid),
        .entry      (entry),
        .ndigits    (ndigits),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // advance n falling edges, counting data_valid samples seen
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (data_valid) pulses++;
        end
    endtask

    task automatic press(input int idx);
        DIP = 10'd1 << idx;
        step(10);
        DIP = '0;
        step(10);
    endtask

    task automatic do_enter();
        enter = 1'b1;
        step(12);
        enter = 1'b0;
        step(10);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(3);
        clear = 1'b0;
        step(4);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pulses  = 0;
        rst   = 1'b0;
        DIP   = '0;
        enter = 1'b0;
        clear = 1'b0;
        step(3);
        chk("rst_datain", 32'(datain), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_entry", 32'(entry), 0);
        chk("rst_ndig", 32'(ndigits), 0);
        rst = 1'b1;
        step(3);

        // T1: 4, 2, enter -> 42 with exact latency and a single pulse
        press(6);
        chk("t1_entry4", 32'(entry), 4);
        chk("t1_ndig1", 32'(ndigits), 1);
        press(8);
        chk("t1_entry42", 32'(entry), 42);
        chk("t1_ndig2", 32'(ndigits), 2);
        pulses = 0;
        enter = 1'b1;
        step(6);
        chk("t1_early", 32'(data_valid), 0);
        step(1);
        chk("t1_valid", 32'(data_valid), 1);
        chk("t1_datain", 32'(datain), 42);
        chk("t1_entry0", 32'(entry), 0);
        step(1);
        chk("t1_vld_drop", 32'(data_valid), 0);
        step(6);
        enter = 1'b0;
        step(10);
        chk("t1_pulses", 32'(pulses), 1);
        chk("t1_hold", 32'(datain), 42);

        // T2: bouncing bit3 then stable hold -> single digit 7
        for (int i = 0; i < 6; i++) begin
            DIP = (i % 2 == 0) ? 10'b0000001000 : 10'b0;
            step(2);
        end
        DIP = 10'b0000001000;
        step(10);
        DIP = '0;
        step(10);
        chk("t2_entry", 32'(entry), 7);
        chk("t2_ndig", 32'(ndigits), 1);
        do_clear();
        chk("t2_clr_entry", 32'(entry), 0);

        // T3: 9, 9, 5 -> 99 with overflow; enter clears overflow
        press(1);
        press(1);
        press(5);
        chk("t3_entry", 32'(entry), 99);
        chk("t3_ndig", 32'(ndigits), 2);
        chk("t3_ovf", 32'(overflow), 1);
        pulses = 0;
        do_enter();
        chk("t3_datain", 32'(datain), 99);
        chk("t3_ovf_clr", 32'(overflow), 0);
        chk("t3_pulses", 32'(pulses), 1);

        // T4: leading zeros dropped
        press(0);
        chk("t4_nd_z1", 32'(ndigits), 0);
        press(0);
        chk("t4_nd_z2", 32'(ndigits), 0);
        chk("t4_entry_z", 32'(entry), 0);
        press(5);
        chk("t4_entry5", 32'(entry), 5);
        do_enter();
        chk("t4_datain", 32'(datain), 5);

        // T5: two keys at once are no key
        DIP = 10'b0000000110;
        step(10);
        DIP = '0;
        step(10);
        chk("t5_entry", 32'(entry), 0);
        chk("t5_ndig", 32'(ndigits), 0);
        press(7);
        chk("t5_entry3", 32'(entry), 3);
        do_clear();

        // T6: clear keeps datain, no pulse; reset mid-debounce aborts
        press(6);
        chk("t6_entry4", 32'(entry), 4);
        pulses = 0;
        do_clear();
        chk("t6_clr_entry", 32'(entry), 0);
        chk("t6_clr_datain", 32'(datain), 5);
        chk("t6_clr_pulse", 32'(pulses), 0);
        press(3);
        chk("t6_entry7", 32'(entry), 7);
        enter = 1'b1;
        step(3);
        rst = 1'b0;
        #1;
        chk("t6_rst_datain", 32'(datain), 0);
        chk("t6_rst_entry", 32'(entry), 0);
        chk("t6_rst_ndig", 32'(ndigits), 0);
        chk("t6_rst_valid", 32'(data_valid), 0);
        enter = 1'b0;
        step(2);
        rst = 1'b1;
        pulses = 0;
        step(15);
        chk("t6_post_pulse", 32'(pulses), 0);
        chk("t6_post_datain", 32'(datain), 0);
        chk("t6_post_entry", 32'(entry), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
